// File: rtl/fourier_pkg.sv
// Shared types and defaults for the Fourier synthesizer frequency sweep.
// Optional bidirectional sweep: FOURIER_SWEEP_BIDIR_EN.
package fourier_pkg;

  localparam int unsigned STEP_W_DEF   = 16;
  localparam int unsigned DWELL_W_DEF  = 16;
  localparam int unsigned DEFAULT_STEP = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DWELL_UP = 2'd1,
    DWELL_DN = 2'd2
  } state_t;

endpackage

// File: rtl/fourier_sweep_ctrl_if.sv
// Sweep descriptor valid/ready channel into fourier_sweep_ctrl.
// Optional bidirectional sweep: FOURIER_SWEEP_BIDIR_EN.
interface fourier_sweep_ctrl_if #(
  parameter int unsigned STEP_W  = fourier_pkg::STEP_W_DEF,
  parameter int unsigned DWELL_W = fourier_pkg::DWELL_W_DEF
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [STEP_W-1:0]  cfg_start_step;
  logic [STEP_W-1:0]  cfg_stop_step;
  logic [STEP_W-1:0]  cfg_inc;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_loop;

  modport master (
    output cfg_valid,
    output cfg_start_step,
    output cfg_stop_step,
    output cfg_inc,
    output cfg_dwell,
    output cfg_loop,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_start_step,
    input  cfg_stop_step,
    input  cfg_inc,
    input  cfg_dwell,
    input  cfg_loop,
    output cfg_ready
  );

endinterface

// File: rtl/fourier_dwell_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
// Optional bidirectional sweep: FOURIER_SWEEP_BIDIR_EN.
module fourier_dwell_timer #(
  parameter int unsigned W = fourier_pkg::DWELL_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/fourier_sweep_ctrl.sv
// Frequency-sweep sequencer driving the synthesizer phase step.
// Optional bidirectional sweep: FOURIER_SWEEP_BIDIR_EN.
module fourier_sweep_ctrl #(
  parameter int unsigned STEP_W       = fourier_pkg::STEP_W_DEF,
  parameter int unsigned DWELL_W      = fourier_pkg::DWELL_W_DEF,
  parameter int unsigned DEFAULT_STEP = fourier_pkg::DEFAULT_STEP
) (
  input  logic              clk,
  input  logic              rst,
  fourier_sweep_ctrl_if.slave cfg,
  input  logic              abort,
  output logic [STEP_W-1:0] phase_step,
  output logic              phase_clr,
  output logic              synth_en,
  output logic [STEP_W-1:0] point_idx,
  output logic              busy,
  output logic              done
);

  import fourier_pkg::*;

  state_t r_state, w_state;

  logic [STEP_W-1:0]  r_start, r_stop, r_inc;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_loop;

  logic [STEP_W-1:0]  r_step, w_step;
  logic [STEP_W-1:0]  r_idx, w_idx;
  logic r_clr, w_clr, r_en, w_en;
  logic r_busy, w_busy, r_done, w_done;

  logic               w_accept, w_load, w_expire, w_tmr_en;
  logic [DWELL_W-1:0] w_load_val;
  logic [STEP_W:0]    w_sum;
  logic               w_up_ok;

  assign cfg.cfg_ready = (r_state == IDLE);
  assign w_accept = cfg.cfg_valid && (r_state == IDLE);
  assign w_tmr_en = (r_state != IDLE);

  // Carry out of the wide sum means the next point is past the range.
  assign w_sum   = {1'b0, r_step} + {1'b0, r_inc};
  assign w_up_ok = (r_inc != '0) && !w_sum[STEP_W] &&
                   (w_sum[STEP_W-1:0] <= r_stop);

  fourier_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .enable   (w_tmr_en),
    .expire   (w_expire)
  );

  always_comb begin
    w_state    = r_state;
    w_step     = r_step;
    w_idx      = r_idx;
    w_clr      = 1'b0;
    w_en       = r_en;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_load     = 1'b0;
    w_load_val = r_dwell;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state    = DWELL_UP;
          w_step     = cfg.cfg_start_step;
          w_idx      = '0;
          w_clr      = 1'b1;
          w_en       = 1'b1;
          w_busy     = 1'b1;
          w_load     = 1'b1;
          w_load_val = cfg.cfg_dwell;
        end
      end
      DWELL_UP: begin
        if (abort) begin
          w_state = IDLE;
          w_en    = 1'b0;
          w_busy  = 1'b0;
        end else if (w_expire) begin
          w_clr  = 1'b1;
          w_load = 1'b1;
          if (w_up_ok) begin
            w_step = w_sum[STEP_W-1:0];
            w_idx  = r_idx + STEP_W'(1);
`ifdef FOURIER_SWEEP_BIDIR_EN
          end else if (r_step != r_start) begin
            w_state = DWELL_DN;
            w_step  = r_step - r_inc;
            w_idx   = r_idx + STEP_W'(1);
`endif
          end else if (r_loop) begin
            w_step = r_start;
            w_idx  = '0;
          end else begin
            w_state = IDLE;
            w_clr   = 1'b0;
            w_load  = 1'b0;
            w_en    = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end
        end
      end
`ifdef FOURIER_SWEEP_BIDIR_EN
      DWELL_DN: begin
        if (abort) begin
          w_state = IDLE;
          w_en    = 1'b0;
          w_busy  = 1'b0;
        end else if (w_expire) begin
          w_clr  = 1'b1;
          w_load = 1'b1;
          w_idx  = r_idx + STEP_W'(1);
          if (r_step != r_start) begin
            w_step = r_step - r_inc;
          end else if (r_loop) begin
            // Start was just visited on the way down; resume one above it.
            w_state = DWELL_UP;
            w_step  = r_start + r_inc;
          end else begin
            w_state = IDLE;
            w_idx   = r_idx;
            w_clr   = 1'b0;
            w_load  = 1'b0;
            w_en    = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state = IDLE;
        w_en    = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_step  <= STEP_W'(DEFAULT_STEP);
      r_idx   <= '0;
      r_clr   <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_step  <= w_step;
      r_idx   <= w_idx;
      r_clr   <= w_clr;
      r_en    <= w_en;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start <= '0;
      r_stop  <= '0;
      r_inc   <= '0;
      r_dwell <= '0;
      r_loop  <= 1'b0;
    end else if (w_accept) begin
      r_start <= cfg.cfg_start_step;
      r_stop  <= cfg.cfg_stop_step;
      r_inc   <= cfg.cfg_inc;
      r_dwell <= cfg.cfg_dwell;
      r_loop  <= cfg.cfg_loop;
    end
  end

  assign phase_step = r_step;
  assign phase_clr  = r_clr;
  assign synth_en   = r_en;
  assign point_idx  = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_fourier_sweep_ctrl.sv
// Self-checking bench for fourier_sweep_ctrl against a point-list model.
// Optional bidirectional sweep: FOURIER_SWEEP_BIDIR_EN.
module tb_fourier_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic [15:0] phase_step, point_idx;
  logic        phase_clr, synth_en, busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_step[$];
  int exp_idx[$];

  fourier_sweep_ctrl_if #(.STEP_W(16), .DWELL_W(16)) cfg ();

  fourier_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg),
    .abort      (abort),
    .phase_step (phase_step),
    .phase_clr  (phase_clr),
    .synth_en   (synth_en),
    .point_idx  (point_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frequency points from the sweep rules, expanded over several passes.
  task automatic build(input int s, input int e, input int inc,
                       input int passes);
    int u[$];
    int p, n, idx, first;
    bit bidir;
    u.delete();
    exp_step.delete();
    exp_idx.delete();
    p = s;
    u.push_back(p);
    if (inc != 0)
      while (p + inc <= e && p + inc <= 65535) begin
        p += inc;
        u.push_back(p);
      end
    n = u.size();
`ifdef FOURIER_SWEEP_BIDIR_EN
    bidir = (n >= 2);
`else
    bidir = 1'b0;
`endif
    idx = 0;
    for (int ps = 0; ps < passes; ps++) begin
      if (bidir) begin
        first = (ps == 0) ? 0 : 1;
        for (int i = first; i < n; i++) begin
          exp_step.push_back(u[i]); exp_idx.push_back(idx); idx++;
        end
        for (int i = n - 2; i >= 0; i--) begin
          exp_step.push_back(u[i]); exp_idx.push_back(idx); idx++;
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          exp_step.push_back(u[i]); exp_idx.push_back(i);
        end
      end
    end
  endtask

  task automatic start(input int s, input int e, input int inc,
                       input int dw, input bit lp);
    logic [31:0] v;
    chk("ready_before_accept", cfg.cfg_ready, 1);
    v = s;  cfg.cfg_start_step = v[15:0];
    v = e;  cfg.cfg_stop_step  = v[15:0];
    v = inc; cfg.cfg_inc       = v[15:0];
    v = dw; cfg.cfg_dwell      = v[15:0];
    cfg.cfg_loop  = lp;
    cfg.cfg_valid = 1'b1;
    tick();
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic check_cycles(input int dw, input int ncyc, input bit junk);
    int k, c;
    for (int t = 0; t < ncyc; t++) begin
      k = t / (dw + 1);
      c = t % (dw + 1);
      chk("phase_step", phase_step, exp_step[k]);
      chk("point_idx", point_idx, exp_idx[k]);
      chk("phase_clr", phase_clr, (c == 0) ? 1 : 0);
      chk("busy", busy, 1);
      chk("synth_en", synth_en, 1);
      chk("done_low", done, 0);
      chk("ready_low", cfg.cfg_ready, 0);
      if (junk) begin
        cfg.cfg_valid      = 1'($urandom_range(0, 1));
        cfg.cfg_start_step = 16'($urandom);
        cfg.cfg_stop_step  = 16'($urandom);
        cfg.cfg_inc        = 16'($urandom);
        cfg.cfg_dwell      = 16'($urandom_range(0, 5));
        cfg.cfg_loop       = 1'($urandom_range(0, 1));
      end
      tick();
    end
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic check_done(input int last);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_synth_en", synth_en, 0);
    chk("done_ready", cfg.cfg_ready, 1);
    chk("done_clr", phase_clr, 0);
    chk("done_step_hold", phase_step, last);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_step_hold", phase_step, last);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_synth_en"}, synth_en, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_clr"}, phase_clr, 0);
    chk({tag, "_ready"}, cfg.cfg_ready, 1);
  endtask

  task automatic run_full(input int s, input int e, input int inc,
                          input int dw, input bit junk);
    build(s, e, inc, 1);
    start(s, e, inc, dw, 1'b0);
    check_cycles(dw, exp_step.size() * (dw + 1), junk);
    check_done(exp_step[exp_step.size() - 1]);
  endtask

  initial begin
    int s, e, inc, dw;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_start_step = '0;
    cfg.cfg_stop_step = '0;
    cfg.cfg_inc = '0;
    cfg.cfg_dwell = '0;
    cfg.cfg_loop = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_step", phase_step, 256);
    chk("rst_idx", point_idx, 0);
    check_idle("rst");
    tick();
    rst = 1'b1;
    tick();
    chk("idle_abort_ignored_pre", busy, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("idle_abort");
    chk("idle_abort_step", phase_step, 256);

    run_full(64, 256, 64, 3, 1'b0);
    run_full(16'hFF00, 16'hFFFF, 16'h0080, 1, 1'b0);
    run_full(500, 1000, 0, 2, 1'b0);
    run_full(300, 200, 64, 2, 1'b0);

    // Looping sweep, cut short by abort
    build(128, 256, 128, 3);
    start(128, 256, 128, 0, 1'b1);
    check_cycles(0, exp_step.size(), 1'b1);
    chk("loop_still_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("loop_abort");

    // Abort during the second cycle of point index 2
    build(64, 1024, 64, 1);
    start(64, 1024, 64, 3, 1'b0);
    check_cycles(3, 9, 1'b0);
    chk("abort_pt_step", phase_step, exp_step[2]);
    chk("abort_pt_clr", phase_clr, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort");
    run_full(1000, 1300, 100, 1, 1'b0);

    // Reset mid-dwell with junk descriptors offered while busy
    build(64, 1024, 64, 1);
    start(64, 1024, 64, 3, 1'b0);
    check_cycles(3, 6, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_step", phase_step, 256);
    chk("mid_rst_idx", point_idx, 0);
    check_idle("mid_rst");
    tick();
    rst = 1'b1;
    tick();
    check_idle("post_rst");

`ifdef FOURIER_SWEEP_BIDIR_EN
    run_full(64, 192, 64, 1, 1'b0);
`endif

    for (int r = 0; r < 8; r++) begin
      s = $urandom_range(0, 65535);
      if ($urandom_range(0, 5) == 0) e = (s > 10) ? s - 10 : s;
      else e = (s + $urandom_range(0, 600) > 65535) ? 65535
                                                    : s + $urandom_range(0, 600);
      inc = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(16, 200);
      dw = $urandom_range(0, 3);
      run_full(s, e, inc, dw, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
